mem_wb_stage: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline outputs.
- Turns the MEM control bits, ALU address and store data into a request/ready transaction on the data-memory bus.
- Stalls upstream stages while an access is outstanding.
- Registers the MEM/WB pipeline values for the writeback stage.

---
 rtl/mem_wb_stage_pkg.sv | 12 +
 rtl/mem_wb_stage_wait_timer.sv | 29 ++
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 tb/tb_mem_wb_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM stage and its wait timer.
package mem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int MEM_RD_BIT = 1;
  localparam int MEM_WR_BIT = 0;
  localparam logic [1:0] WB_NONE = 2'b00;

  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait > 1) ? $clog2(max_wait) : 1;
  endfunction
endpackage

// File: rtl/mem_wb_stage_wait_timer.sv
// Counts BUSY cycles without a memory response; expire flags the final allowed cycle.
module mem_wait_timer
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = wait_cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == LAST);
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: drives the data-memory request/ready bus, stalls upstream, registers MEM/WB.
// Define MEM_MISALIGN_TRAP_EN to retire misaligned accesses without a bus request.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        WB_in,
  input  logic [1:0]        Mem_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] WriteData_in,
  input  logic [REG_W-1:0]  rdAddr_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic [1:0]        WB_out,
  output logic [DATA_W-1:0] ReadData_wb,
  output logic [DATA_W-1:0] ALUResult_wb,
  output logic [REG_W-1:0]  rdAddr_wb,
  output logic              valid_wb,
  output logic              bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);
  state_t            state;
  logic [1:0]        req_wb;
  logic [REG_W-1:0]  req_rd;
  logic              access;
  logic              mis;
  logic              issue;
  logic              in_idle;
  logic              in_busy;
  logic              expire;

  assign access  = Mem_in[MEM_RD_BIT] | Mem_in[MEM_WR_BIT];
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis     = access & (ALUResult_in[1:0] != 2'b00);
`else
  assign mis     = 1'b0;
`endif
  assign issue   = access & ~mis;
  assign in_idle = (state == IDLE);
  assign in_busy = (state == BUSY);

  // Stall is gated by reset so an in-flight access vanishes the moment rst_n drops.
  assign dmem_req = in_busy;
  assign stall    = rst_n & ((in_idle & issue) | (in_busy & ~dmem_ready & ~expire));

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (in_idle & issue),
    .en     (in_busy & ~dmem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      req_wb       <= WB_NONE;
      req_rd       <= '0;
      WB_out       <= WB_NONE;
      ReadData_wb  <= '0;
      ALUResult_wb <= '0;
      rdAddr_wb    <= '0;
      valid_wb     <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign     <= 1'b0;
`endif
    end else begin
      bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_we     <= Mem_in[MEM_WR_BIT];
            dmem_addr   <= ALUResult_in;
            dmem_wdata  <= WriteData_in;
            req_wb      <= WB_in;
            req_rd      <= rdAddr_in;
            WB_out      <= WB_NONE;
            ReadData_wb <= '0;
            valid_wb    <= 1'b0;
            state       <= BUSY;
          end else begin
            WB_out       <= mis ? WB_NONE : WB_in;
            ALUResult_wb <= ALUResult_in;
            rdAddr_wb    <= rdAddr_in;
            ReadData_wb  <= '0;
            valid_wb     <= access | (WB_in != WB_NONE);
`ifdef MEM_MISALIGN_TRAP_EN
            misalign     <= mis;
`endif
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            WB_out       <= req_wb;
            ALUResult_wb <= dmem_addr;
            rdAddr_wb    <= req_rd;
            ReadData_wb  <= dmem_we ? '0 : dmem_rdata;
            valid_wb     <= 1'b1;
            state        <= IDLE;
          end else if (expire) begin
            // Timed-out access still retires so the pipeline keeps its slot count.
            WB_out       <= WB_NONE;
            ALUResult_wb <= dmem_addr;
            rdAddr_wb    <= req_rd;
            ReadData_wb  <= '0;
            valid_wb     <= 1'b1;
            bus_err      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a transaction-level reference model and directed literal checks.
module tb_mem_wb_stage;
  localparam int DATA_W = 32, REG_W = 5, MAX_WAIT = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] WB_in, Mem_in;
  logic [DATA_W-1:0] ALUResult_in, WriteData_in, dmem_rdata;
  logic [REG_W-1:0] rdAddr_in;
  logic dmem_ready;
  logic dmem_req, dmem_we, stall, valid_wb, bus_err;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, ReadData_wb, ALUResult_wb;
  logic [1:0] WB_out;
  logic [REG_W-1:0] rdAddr_wb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif

  mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .WB_in(WB_in), .Mem_in(Mem_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .rdAddr_in(rdAddr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall), .WB_out(WB_out),
    .ReadData_wb(ReadData_wb), .ALUResult_wb(ALUResult_wb), .rdAddr_wb(rdAddr_wb),
    .valid_wb(valid_wb), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] mem, input logic [DATA_W-1:0] alu);
    logic [DATA_W-1:0] a;
    a = alu;
`ifdef MEM_MISALIGN_TRAP_EN
    return (mem != 2'b00) && (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one outstanding memory transaction and the retired MEM/WB slot.
  bit m_busy = 0;
  int m_wait = 0;
  logic [DATA_W-1:0] m_addr = '0, m_wdata = '0;
  bit m_we = 0;
  logic [1:0] m_wbc = '0;
  logic [REG_W-1:0] m_rd = '0;
  logic [1:0] e_wb = '0;
  logic [DATA_W-1:0] e_rdata = '0, e_alu = '0;
  logic [REG_W-1:0] e_rd = '0;
  bit e_valid = 0, e_err = 0, e_mis = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_we = 0; m_wbc = '0; m_rd = '0;
      e_wb = '0; e_rdata = '0; e_alu = '0; e_rd = '0; e_valid = 0; e_err = 0; e_mis = 0;
    end else begin
      e_err = 0; e_mis = 0;
      if (!m_busy) begin
        if (Mem_in != 2'b00 && !is_mis(Mem_in, ALUResult_in)) begin
          m_busy = 1; m_wait = 0;
          m_addr = ALUResult_in; m_wdata = WriteData_in; m_we = Mem_in[0];
          m_wbc = WB_in; m_rd = rdAddr_in;
          e_wb = 2'b00; e_valid = 0; e_rdata = '0;
        end else begin
          e_mis   = is_mis(Mem_in, ALUResult_in);
          e_wb    = e_mis ? 2'b00 : WB_in;
          e_alu   = ALUResult_in;
          e_rd    = rdAddr_in;
          e_rdata = '0;
          e_valid = (WB_in != 2'b00) || (Mem_in != 2'b00);
        end
      end else if (dmem_ready) begin
        e_wb = m_wbc; e_alu = m_addr; e_rd = m_rd;
        e_rdata = m_we ? '0 : dmem_rdata; e_valid = 1; m_busy = 0;
      end else if (m_wait == MAX_WAIT - 1) begin
        e_wb = 2'b00; e_alu = m_addr; e_rd = m_rd; e_rdata = '0;
        e_valid = 1; e_err = 1; m_busy = 0;
      end else begin
        m_wait++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_stall;
      if (m_busy) exp_stall = !dmem_ready && (m_wait < MAX_WAIT - 1);
      else exp_stall = (Mem_in != 2'b00) && !is_mis(Mem_in, ALUResult_in);
      chk("dmem_req", dmem_req, m_busy);
      chk("stall", stall, rst_n && exp_stall);
      if (m_busy) begin
        chk("dmem_addr", dmem_addr, m_addr);
        chk("dmem_we", dmem_we, m_we);
        chk("dmem_wdata", dmem_wdata, m_wdata);
      end
      chk("WB_out", WB_out, e_wb);
      chk("valid_wb", valid_wb, e_valid);
      chk("bus_err", bus_err, e_err);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign", misalign, e_mis);
`endif
      if (e_valid) begin
        chk("ReadData_wb", ReadData_wb, e_rdata);
        chk("ALUResult_wb", ALUResult_wb, e_alu);
        chk("rdAddr_wb", rdAddr_wb, e_rd);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd);
    WB_in = wb; Mem_in = mem; ALUResult_in = alu; WriteData_in = wd; rdAddr_in = rd;
  endtask

  task automatic rand_inputs;
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    drive(2'($urandom), ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00, a, $urandom, 5'($urandom));
  endtask

  initial begin
    int nst, nbusy, thr;
    bit adv;
    rand_inputs();
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    chk_on = 1'b1;

    // Reset held with random inputs: every output is zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", dmem_req, 0); chk("rst_stall", stall, 0); chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0); chk("rst_wdata", dmem_wdata, 0); chk("rst_wb", WB_out, 0);
      chk("rst_rdata", ReadData_wb, 0); chk("rst_alu", ALUResult_wb, 0); chk("rst_rd", rdAddr_wb, 0);
      chk("rst_valid", valid_wb, 0); chk("rst_err", bus_err, 0);
      tick();
      rand_inputs(); dmem_ready = 1'($urandom);
    end
    drive(0, 0, 0, 0, 0); dmem_ready = 0;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("bubble_valid", valid_wb, 0);

    // ALU pass-through.
    tick();
    drive(2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk);
    chk("pass_stall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pass_alu", ALUResult_wb, 32'h1234); chk("pass_rd", rdAddr_wb, 5);
    chk("pass_valid", valid_wb, 1); chk("pass_wb", WB_out, 2'b10);

    // Load answered on the fourth BUSY cycle.
    tick();
    drive(2'b01, 2'b10, 32'h100, 32'h0, 5'd3);
    dmem_ready = 0; dmem_rdata = 32'hDEADBEEF; nst = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) dmem_ready = 1;
      @(negedge clk);
      if (stall) nst++;
      if (c > 0) begin
        chk("ld_req", dmem_req, 1); chk("ld_addr", dmem_addr, 32'h100); chk("ld_we", dmem_we, 0);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0); dmem_ready = 0;
    @(negedge clk);
    chk("ld_stall_cycles", nst, 4);
    chk("ld_rdata", ReadData_wb, 32'hDEADBEEF); chk("ld_valid", valid_wb, 1);
    chk("ld_wb", WB_out, 2'b01); chk("ld_rd", rdAddr_wb, 3);

    // Store with single-cycle ready.
    tick();
    drive(2'b00, 2'b01, 32'h20, 32'hA5A5A5A5, 5'd0); dmem_ready = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("st_idle_stall", stall, 1);
    tick();
    @(negedge clk);
    chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5); chk("st_addr", dmem_addr, 32'h20); chk("st_stall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0); dmem_ready = 0;
    @(negedge clk);
    chk("st_rdata", ReadData_wb, 0); chk("st_valid", valid_wb, 1); chk("st_req_done", dmem_req, 0);

    // Timeout: ready never arrives.
    tick();
    drive(2'b01, 2'b10, 32'h40, 32'h0, 5'd7); dmem_ready = 0;
    tick();
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!dmem_req) break;
      nbusy++;
      adv = !stall;
      tick();
      if (adv) drive(0, 0, 0, 0, 0);
    end
    chk("to_busy_cycles", nbusy, 15);
    chk("to_err", bus_err, 1); chk("to_wb", WB_out, 0); chk("to_valid", valid_wb, 1);
    chk("to_rdata", ReadData_wb, 0);
    tick();
    @(negedge clk);
    chk("to_err_pulse", bus_err, 0); chk("to_idle", dmem_req, 0);

    // Reset in the second BUSY cycle, then a normal load.
    tick();
    drive(2'b01, 2'b10, 32'h80, 32'h0, 5'd9); dmem_ready = 0; dmem_rdata = 32'h13579BDF;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0); chk("mid_rst_stall", stall, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", stall, 1);
    tick();
    dmem_ready = 1;
    @(negedge clk);
    chk("post_rst_req", dmem_req, 1); chk("post_rst_addr", dmem_addr, 32'h80);
    tick();
    drive(0, 0, 0, 0, 0); dmem_ready = 0;
    @(negedge clk);
    chk("post_rst_rdata", ReadData_wb, 32'h13579BDF); chk("post_rst_valid", valid_wb, 1);
    chk("post_rst_rd", rdAddr_wb, 9);

    // Randomized traffic with varying memory responsiveness.
    for (int blk = 0; blk < 30; blk++) begin
      thr = $urandom_range(0, 8);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        adv = !stall;
        tick();
        if (adv) rand_inputs();
        dmem_ready = ($urandom_range(0, 7) < thr);
        dmem_rdata = $urandom;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
